cla_seq_adder: RTL



---
 rtl/cla_pkg.sv | 13 +
 rtl/cla_seq_adder_cla4_slice.sv | 29 ++
 rtl/cla_seq_adder.sv | 117 +++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared types for the nibble-serial lookahead adder: slice width and sequencer states.
// Pure declarations; no timing or flow-control behaviour of its own.
package cla_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_seq_adder_cla4_slice.sv
// Combinational 4-bit generate/propagate carry-lookahead adder.
// Zero latency, no flow control.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is flattened to a two-level function of g, p and cin.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/cla_seq_adder.sv
// Adds two WIDTH-bit operands one nibble per cycle through a single 4-bit lookahead slice; result valid WIDTH/4+1 cycles after accept.
// Result is held in DONE until out_ready; no new operand is taken until then. CLA_SUB_EN adds the sub port (A-B).
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = $clog2(NSLICE);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               c_q, c_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;

  assign slice_a = opa_q[SLICE_W*idx_q +: SLICE_W];
  assign slice_b = opb_q[SLICE_W*idx_q +: SLICE_W];

  cla4_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (c_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    c_d     = c_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opa_d   = a;
`ifdef CLA_SUB_EN
          // Two's-complement subtract: A + ~B + 1.
          opb_d   = sub ? ~b : b;
          c_d     = sub ? 1'b1 : cin;
`else
          opb_d   = b;
          c_d     = cin;
`endif
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[SLICE_W*idx_q +: SLICE_W] = slice_sum;
        c_d = slice_cout;
        if (idx_q == IDX_W'(NSLICE - 1)) begin
          cout_d  = slice_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      c_q     <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule
